// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-seeds from the first WIDTH valid bits, then predicts each
// following bit from the Fibonacci recurrence, counting mismatches and resyncing on error bursts.
module lfsr_checker #(
   parameter int unsigned          WIDTH         = 4,
   parameter logic [WIDTH-1:0]     TAPS          = 4'b1100,
   parameter int unsigned          WINDOW        = 15,
   parameter int unsigned          LOSS_THRESH   = 4,
   parameter int unsigned          ERR_CNT_WIDTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ENABLE,
   input  logic                     DIN,
   input  logic                     DIN_VALID,
   input  logic                     CLR_ERR,
   output logic                     LOCKED,
   output logic                     ERR,
   output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
   output logic [7:0]               RESYNC_CNT
);

   localparam int unsigned FILL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] THRESH    = WERR_W'(LOSS_THRESH);

   typedef enum logic {SEARCH, CHECK} state_t;

   state_t                   r_fsm, w_fsm_nxt;
   logic [WIDTH-1:0]         r_state, w_state_nxt;
   logic [FILL_W-1:0]        r_fill, w_fill_nxt;
   logic [WIN_W-1:0]         r_win, w_win_nxt;
   logic [WERR_W-1:0]        r_werr, w_werr_nxt, w_werr_sum;
   logic                     r_err;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
   logic [7:0]               r_resync;
   logic                     w_exp, w_mis, w_resync_inc;
   logic [WIDTH-1:0]         w_shift_din, w_shift_exp;

   assign w_exp       = ^(r_state & TAPS);
   assign w_shift_din = {r_state[WIDTH-2:0], DIN};
   assign w_shift_exp = {r_state[WIDTH-2:0], w_exp};
   assign w_werr_sum  = r_werr + WERR_W'(w_mis);

   always_comb begin
      w_fsm_nxt    = r_fsm;
      w_state_nxt  = r_state;
      w_fill_nxt   = r_fill;
      w_win_nxt    = r_win;
      w_werr_nxt   = r_werr;
      w_mis        = 1'b0;
      w_resync_inc = 1'b0;
      if (!ENABLE) begin
         w_fsm_nxt  = SEARCH;
         w_fill_nxt = '0;
         w_win_nxt  = '0;
         w_werr_nxt = '0;
      end else if (DIN_VALID) begin
         case (r_fsm)
            SEARCH: begin
               w_state_nxt = w_shift_din;
               if (r_fill == FILL_LAST) begin
                  // All-zero seed would lock the LFSR up; refill instead of locking.
                  w_fill_nxt = '0;
                  if (w_shift_din != '0) begin
                     w_fsm_nxt  = CHECK;
                     w_win_nxt  = '0;
                     w_werr_nxt = '0;
                  end
               end else begin
                  w_fill_nxt = r_fill + 1'b1;
               end
            end
            CHECK: begin
               // The prediction, not DIN, feeds back so one bad bit costs one error.
               w_state_nxt = w_shift_exp;
               w_mis       = (DIN != w_exp);
               if (w_werr_sum >= THRESH) begin
                  w_fsm_nxt    = SEARCH;
                  w_fill_nxt   = '0;
                  w_win_nxt    = '0;
                  w_werr_nxt   = '0;
                  w_resync_inc = 1'b1;
               end else if (r_win == WIN_LAST) begin
                  w_win_nxt  = '0;
                  w_werr_nxt = '0;
               end else begin
                  w_win_nxt  = r_win + 1'b1;
                  w_werr_nxt = w_werr_sum;
               end
            end
            default: w_fsm_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_fsm     <= SEARCH;
         r_state   <= '0;
         r_fill    <= '0;
         r_win     <= '0;
         r_werr    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_resync  <= '0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_state <= w_state_nxt;
         r_fill  <= w_fill_nxt;
         r_win   <= w_win_nxt;
         r_werr  <= w_werr_nxt;
         r_err   <= w_mis;
         if (CLR_ERR)
            r_err_cnt <= ERR_CNT_WIDTH'(w_mis);
         else if (w_mis && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
         if (w_resync_inc && (r_resync != '1))
            r_resync <= r_resync + 1'b1;
      end
   end

   assign LOCKED     = (r_fsm == CHECK);
   assign ERR        = r_err;
   assign ERR_CNT    = r_err_cnt;
   assign RESYNC_CNT = r_resync;

endmodule
